// File: rtl/pixel_stream_feeder_if.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_stream_feeder_if
//  Purpose  : Memory-request, read-data and video handshake bundle for the
//             pixel stream feeder.
//  Revision : 1.0  initial release
// ============================================================================
interface pixel_stream_feeder_if #(
    parameter int ADDR_W = 31,
    parameter int DATA_W = 128
);
    logic              af_full;
    logic              af_wr_en;
    logic [ADDR_W-1:0] af_addr_din;
    logic              rdf_valid;
    logic [DATA_W-1:0] rdf_dout;
    logic              rdf_rd_en;
    logic [23:0]       video;
    logic              video_valid;
    logic              video_ready;

    modport master (
        input  af_full, rdf_valid, rdf_dout, video_ready,
        output af_wr_en, af_addr_din, rdf_rd_en, video, video_valid
    );

    modport slave (
        output af_full, rdf_valid, rdf_dout, video_ready,
        input  af_wr_en, af_addr_din, rdf_rd_en, video, video_valid
    );
endinterface
`default_nettype wire

// File: rtl/pixel_stream_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : pixel_stream_feeder
//  Purpose  : Credit-limited burst reader of a double-buffered frame that
//             unpacks memory words into pixels on a ready/valid video port.
//             Optional chroma keying when CHROMA_KEY_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module pixel_stream_feeder #(
    parameter int WIDTH       = 800,
    parameter int HEIGHT      = 600,
    parameter int DATA_W      = 128,
    parameter int PIX_W       = 32,
    parameter int ADDR_W      = 31,
    parameter int BURST_WORDS = 2,
    parameter int ADDR_STEP   = 8,
    parameter int FIFO_DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [ADDR_W-1:0] frame_base,
`ifdef CHROMA_KEY_EN
    input  logic [23:0]       key_color,
    input  logic [7:0]        key_tol,
    input  logic [23:0]       bg_color,
`endif
    output logic              frame_start,
    output logic              underflow,
    pixel_stream_feeder_if.master bus
);

    localparam int c_ppw       = DATA_W / PIX_W;
    localparam int c_pix_total = WIDTH * HEIGHT;
    localparam int c_reqs      = c_pix_total / (c_ppw * BURST_WORDS);
    localparam int c_ptr_w     = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w     = c_ptr_w + 1;
    localparam int c_idx_w     = (c_ppw > 1) ? $clog2(c_ppw) : 1;
    localparam int c_req_w     = (c_reqs > 1) ? $clog2(c_reqs) : 1;
    localparam int c_pix_w     = (c_pix_total > 1) ? $clog2(c_pix_total) : 1;

    localparam logic [c_idx_w-1:0] c_last_slot = c_idx_w'(c_ppw - 1);
    localparam logic [c_req_w-1:0] c_last_req  = c_req_w'(c_reqs - 1);
    localparam logic [c_pix_w-1:0] c_last_pix  = c_pix_w'(c_pix_total - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [c_req_w-1:0]  r_req_cnt;
    logic [c_cnt_w-1:0]  r_outstanding;
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_fifo_count;
    logic [c_idx_w-1:0]  r_pix_idx;
    logic [c_pix_w-1:0]  r_pix_cnt;
    logic                r_frame_start;
    logic                r_underflow;
    logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];

    logic                w_fetch;
    logic [c_cnt_w+1:0]  w_credit_sum;
    logic                w_credit_ok;
    logic                w_req;
    logic                w_pop_mem;
    logic                w_push;
    logic                w_valid;
    logic                w_accept;
    logic                w_pop_word;
    logic [c_cnt_w-1:0]  w_out_next;
    logic [23:0]         w_slots [c_ppw];
    logic [23:0]         w_pixel;
    logic [23:0]         w_video;

    assign w_fetch = (r_state == ST_FETCH);

    // Reserve FIFO room for every word already requested so returning data
    // can always be accepted without a back-pressure path to memory.
    assign w_credit_sum = (c_cnt_w+2)'(r_outstanding) + (c_cnt_w+2)'(r_fifo_count)
                        + (c_cnt_w+2)'(BURST_WORDS);
    assign w_credit_ok  = (w_credit_sum <= (c_cnt_w+2)'(FIFO_DEPTH));
    assign w_req        = w_fetch && !bus.af_full && w_credit_ok;

    assign w_pop_mem  = bus.rdf_valid;
    assign w_push     = w_pop_mem && w_fetch;
    assign w_valid    = w_fetch && (r_fifo_count != '0);
    assign w_accept   = w_valid && bus.video_ready;
    assign w_pop_word = w_accept && (r_pix_idx == c_last_slot);

    for (genvar g = 0; g < c_ppw; g++) begin : g_slot
        assign w_slots[g] = r_mem[r_rd_ptr][g*PIX_W +: 24];
    end
    assign w_pixel = w_slots[r_pix_idx];

`ifdef CHROMA_KEY_EN
    function automatic logic [7:0] abs_diff8(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    logic w_key_hit;
    assign w_key_hit = (abs_diff8(w_pixel[23:16], key_color[23:16]) <= key_tol)
                    && (abs_diff8(w_pixel[15:8],  key_color[15:8])  <= key_tol)
                    && (abs_diff8(w_pixel[7:0],   key_color[7:0])   <= key_tol);
    assign w_video   = w_key_hit ? bg_color : w_pixel;
`else
    assign w_video   = w_pixel;
`endif

    always_comb begin
        w_out_next = r_outstanding;
        if (w_req)
            w_out_next = w_out_next + c_cnt_w'(BURST_WORDS);
        if (w_pop_mem)
            w_out_next = w_out_next - c_cnt_w'(1);
    end

    assign bus.af_wr_en    = w_req;
    assign bus.af_addr_din = r_addr;
    assign bus.rdf_rd_en   = bus.rdf_valid;
    assign bus.video_valid = w_valid;
    assign bus.video       = w_valid ? w_video : 24'd0;
    assign frame_start     = r_frame_start;
    assign underflow       = r_underflow;

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= bus.rdf_dout;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_addr        <= '0;
            r_req_cnt     <= '0;
            r_outstanding <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_fifo_count  <= '0;
            r_pix_idx     <= '0;
            r_pix_cnt     <= '0;
            r_frame_start <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            r_frame_start <= w_accept && (r_pix_cnt == '0);

            if (r_state != ST_IDLE)
                r_outstanding <= w_out_next;

            // The new base is only picked up as the last request of a frame issues.
            if (w_req) begin
                if (r_req_cnt == c_last_req) begin
                    r_addr    <= frame_base;
                    r_req_cnt <= '0;
                end else begin
                    r_addr    <= r_addr + ADDR_W'(ADDR_STEP);
                    r_req_cnt <= r_req_cnt + c_req_w'(1);
                end
            end

            if (w_push)
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_pop_word)
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            if (w_push && !w_pop_word)
                r_fifo_count <= r_fifo_count + c_cnt_w'(1);
            else if (!w_push && w_pop_word)
                r_fifo_count <= r_fifo_count - c_cnt_w'(1);

            if (w_accept) begin
                r_pix_idx <= (r_pix_idx == c_last_slot) ? '0 : r_pix_idx + c_idx_w'(1);
                r_pix_cnt <= (r_pix_cnt == c_last_pix)  ? '0 : r_pix_cnt + c_pix_w'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_state     <= ST_FETCH;
                        r_addr      <= frame_base;
                        r_req_cnt   <= '0;
                        r_underflow <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (!enable)
                        r_state <= ST_DRAIN;
                    if (bus.video_ready && !w_valid && (r_pix_cnt != '0))
                        r_underflow <= 1'b1;
                end
                ST_DRAIN: begin
                    if (r_outstanding == '0) begin
                        r_state      <= ST_IDLE;
                        r_wr_ptr     <= '0;
                        r_rd_ptr     <= '0;
                        r_fifo_count <= '0;
                        r_pix_idx    <= '0;
                        r_pix_cnt    <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pixel_stream_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pixel_stream_feeder
//  Purpose  : Self-checking bench for pixel_stream_feeder (8x2 frame, 8-deep FIFO).
//  Revision : 1.0  initial release
// ============================================================================
module tb_pixel_stream_feeder;
    localparam int WIDTH = 8, HEIGHT = 2, DATA_W = 128, PIX_W = 32, ADDR_W = 31;
    localparam int BURST = 2, STEP = 8, DEPTH = 8;
    localparam int PPW = DATA_W / PIX_W;
    localparam int FRAME = WIDTH * HEIGHT;
    localparam int REQS = FRAME / (PPW * BURST);

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable;
    logic [ADDR_W-1:0] frame_base;
    logic              frame_start;
    logic              underflow;

    pixel_stream_feeder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) vif ();

`ifdef CHROMA_KEY_EN
    logic [23:0] key_color = 24'h00FF00;
    logic [7:0]  key_tol   = 8'd4;
    logic [23:0] bg_color  = 24'h0000FF;
`endif

    pixel_stream_feeder #(
        .WIDTH(WIDTH), .HEIGHT(HEIGHT), .DATA_W(DATA_W), .PIX_W(PIX_W), .ADDR_W(ADDR_W),
        .BURST_WORDS(BURST), .ADDR_STEP(STEP), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .frame_base(frame_base),
`ifdef CHROMA_KEY_EN
        .key_color(key_color),
        .key_tol(key_tol),
        .bg_color(bg_color),
`endif
        .frame_start(frame_start),
        .underflow(underflow),
        .bus(vif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Slot content is derived from where it lives so every pixel is traceable.
    function automatic logic [23:0] pv(input logic [ADDR_W-1:0] a, input int beat, input int slot);
        logic [11:0] a12;
        a12 = a[11:0];
        return {4'h0, a12, 4'(beat), 4'(slot)};
    endfunction

    function automatic logic [DATA_W-1:0] mk_word(input logic [ADDR_W-1:0] a, input int beat);
        logic [DATA_W-1:0] w;
        w = '0;
        for (int s = 0; s < PPW; s++)
            w[s*PIX_W +: PIX_W] = {8'hEE, pv(a, beat, s)};
        return w;
    endfunction

    function automatic logic [23:0] keyed(input logic [23:0] p);
`ifdef CHROMA_KEY_EN
        int dr, dg, db;
        dr = int'(p[23:16]) - 32'sd0;   dg = int'(p[15:8]) - 32'sd255;  db = int'(p[7:0]);
        if (dr < 0) dr = -dr;
        if (dg < 0) dg = -dg;
        if (db < 0) db = -db;
        if (dr <= 4 && dg <= 4 && db <= 4) return 24'h0000FF;
`endif
        return p;
    endfunction

    // ---------------- memory model: returns BURST words per request ----------
    typedef struct { logic [ADDR_W-1:0] a; int beat; int t; } resp_t;
    resp_t mq[$];
    int    cyc = 0;
    int    mem_lat = 3;
    int    mem_budget = -1;   // -1 unlimited, otherwise words still allowed back

    initial begin
        vif.rdf_valid = 1'b0;
        vif.rdf_dout  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mq.delete();
            end else begin
                if (vif.rdf_valid && vif.rdf_rd_en) begin
                    void'(mq.pop_front());
                    if (mem_budget > 0) mem_budget--;
                end
                if (vif.af_wr_en)
                    for (int b = 0; b < BURST; b++)
                        mq.push_back('{vif.af_addr_din, b, cyc + mem_lat});
            end
            @(posedge clk);
            cyc++;
            #1;
            if (rst_n && mq.size() > 0 && mq[0].t <= cyc && mem_budget != 0) begin
                vif.rdf_valid = 1'b1;
                vif.rdf_dout  = mk_word(mq[0].a, mq[0].beat);
            end else begin
                vif.rdf_valid = 1'b0;
                vif.rdf_dout  = '0;
            end
        end
    end

    // ---------------- reference model + per-cycle compare --------------------
    int                m_state, m_out, m_pix, m_n, m_r, old_out, old_n;
    logic [DATA_W-1:0] m_q[$];
    logic [ADDR_W-1:0] m_base, cur_fb;
    logic [ADDR_W-1:0] fbq[$];
    logic [ADDR_W-1:0] req_log[$];
    logic [23:0]       acc_log[$];
    bit                m_under, m_fs, e_req, e_valid, acc, fetch;
    logic [23:0]       e_video;
    int                fs_count = 0;

    initial begin
        m_state = 0; m_out = 0; m_pix = 0; m_n = 0; m_r = 0; m_under = 0; m_fs = 0;
        m_base = '0; cur_fb = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_state = 0; m_out = 0; m_pix = 0; m_n = 0; m_r = 0;
                m_under = 0; m_fs = 0; m_q.delete(); fbq.delete();
            end else begin
                fetch   = (m_state == 1);
                e_req   = fetch && !vif.af_full && (m_out + m_q.size() + BURST <= DEPTH);
                e_valid = fetch && (m_q.size() > 0);
                e_video = e_valid ? keyed(m_q[0][m_pix*PIX_W +: 24]) : 24'd0;

                check("af_wr_en", vif.af_wr_en, e_req);
                if (e_req) check("af_addr", vif.af_addr_din, m_base + ADDR_W'(STEP * m_r));
                check("video_valid", vif.video_valid, e_valid);
                check("video", vif.video, e_video);
                check("frame_start", frame_start, m_fs);
                check("underflow", underflow, m_under);
                check("rdf_rd_en", vif.rdf_rd_en, vif.rdf_valid);

                if (vif.af_wr_en) req_log.push_back(vif.af_addr_din);
                if (frame_start) fs_count++;

                acc     = e_valid && vif.video_ready;
                old_out = m_out;
                old_n   = m_n;
                if (fetch && vif.video_ready && !e_valid && m_n != 0) m_under = 1;
                m_fs = acc && (m_n == 0);

                // Frame-order view: pixel n of a frame comes from request n/8, beat, slot.
                if (acc) begin
                    if (m_n == 0) begin
                        if (fbq.size() == 0) check("frame_base_known", 1, 0);
                        else cur_fb = fbq.pop_front();
                    end
                    check("stream_order", vif.video,
                          keyed(pv(cur_fb + ADDR_W'(STEP * (m_n / (PPW*BURST))),
                                   (m_n / PPW) % BURST, m_n % PPW)));
                    acc_log.push_back(vif.video);
                    m_pix++;
                    if (m_pix == PPW) begin m_pix = 0; void'(m_q.pop_front()); end
                    m_n = (m_n + 1) % FRAME;
                end
                if (vif.rdf_valid && fetch) m_q.push_back(vif.rdf_dout);

                if (e_req) begin
                    if (m_r == 0) fbq.push_back(m_base);
                    m_r++;
                    if (m_r == REQS) begin m_r = 0; m_base = frame_base; end
                end
                if (m_state != 0) m_out = m_out + (e_req ? BURST : 0) - (vif.rdf_valid ? 1 : 0);

                case (m_state)
                    0: if (enable) begin m_state = 1; m_base = frame_base; m_r = 0; m_under = 0; end
                    1: if (!enable) m_state = 2;
                    default: if (old_out == 0) begin
                        m_state = 0; m_q.delete(); fbq.delete(); m_pix = 0; m_n = 0;
                    end
                endcase
                if (old_n < 0) check("model_sane", old_n, 0);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    int n0, n1, a0;
    bit ok;

    initial begin
        rst_n = 1'b0; enable = 1'b0; frame_base = 31'h100;
        vif.af_full = 1'b0; vif.video_ready = 1'b0;
        step(3);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_af_wr_en", vif.af_wr_en, 1'b0);
        check("rst_af_addr", vif.af_addr_din, 31'h0);
        check("rst_video_valid", vif.video_valid, 1'b0);
        check("rst_video", vif.video, 24'h0);
        check("rst_frame_start", frame_start, 1'b0);
        check("rst_underflow", underflow, 1'b0);
`ifdef CHROMA_KEY_EN
        check("model_key_hit", keyed(24'h03FC02), 24'h0000FF);
        check("model_key_pass", keyed(24'h05FF00), 24'h05FF00);
`endif

        // Basic frame streaming
        step(1);
        vif.video_ready = 1'b1; enable = 1'b1;
        ok = 0;
        for (int i = 0; i < 600 && !ok; i++) begin step(1); ok = (acc_log.size() >= 34); end
        check("basic_progress", ok, 1'b1);
        check("basic_req0", req_log[0], 31'h100);
        check("basic_req1", req_log[1], 31'h108);
        check("basic_req2", req_log[2], 31'h100);
        check("basic_pix0", acc_log[0], 24'h010000);
        check("basic_pix5", acc_log[5], 24'h010011);
        check("basic_pix9", acc_log[9], 24'h010801);
        check("basic_pix15", acc_log[15], 24'h010813);
        check("basic_pix16", acc_log[16], 24'h010000);
        check("basic_fs_seen", fs_count >= 2, 1'b1);

        // Address FIFO full blocks requests; sink toggling must not lose pixels
        vif.af_full = 1'b1; n0 = req_log.size();
        step(10);
        check("af_full_block", req_log.size() - n0, 0);
        vif.af_full = 1'b0;
        a0 = acc_log.size();
        for (int i = 0; i < 60; i++) begin
            vif.video_ready = (i % 3 != 0);
            step(1);
        end
        vif.video_ready = 1'b1;
        check("bp_progress", acc_log.size() > a0, 1'b1);

        // Base change mid-frame takes effect at the next frame
        n0 = req_log.size(); ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin
            step(1);
            ok = (req_log.size() > n0) && (req_log[req_log.size()-1] == 31'h100);
        end
        check("db_sync", ok, 1'b1);
        frame_base = 31'h400; n1 = req_log.size(); ok = 0;
        for (int i = 0; i < 200 && !ok; i++) begin step(1); ok = (req_log.size() >= n1 + 2); end
        check("db_wait", ok, 1'b1);
        check("db_finish_old", req_log[n1], 31'h108);
        check("db_next_new", req_log[n1+1], 31'h400);
        step(40);

        // Drain, then credit limit with no data returning
        enable = 1'b0;
        step(40);
        mem_budget = 0; n0 = req_log.size(); enable = 1'b1;
        step(30);
        check("credit_reqs", req_log.size() - n0, 4);
        check("credit_first_addr", req_log[n0], 31'h400);
        check("no_underflow_before_pixel0", underflow, 1'b0);

        // One word back: 4 pixels then empty mid-frame
        mem_budget = 1;
        step(15);
        check("underflow_set", underflow, 1'b1);
        step(10);
        check("underflow_sticky", underflow, 1'b1);
        enable = 1'b0;
        step(5);
        mem_budget = -1;
        step(30);
        check("underflow_held_idle", underflow, 1'b1);
        n0 = req_log.size(); enable = 1'b1;
        step(2);
        check("underflow_cleared", underflow, 1'b0);
        step(10);
        check("relaunch_req", req_log.size() > n0, 1'b1);
        check("relaunch_addr", req_log[n0], 31'h400);
        step(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
